keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_if.sv | 10 +
 rtl/keypad_emulator.sv | 106 ++++++++++
 tb/tb_keypad_emulator.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// keypad_if: press request, row drives and column/status outputs of the keypad emulator
interface keypad_if;
  logic [3:0] key_code;
  logic press;
  logic B, G, F, D;
  logic C, A, E;
  logic busy, done, err;
  modport master (output key_code, press, B, G, F, D, input C, A, E, busy, done, err);
  modport slave (input key_code, press, B, G, F, D, output C, A, E, busy, done, err);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: emulates a 4x3 matrix keypad press; optional contact bounce via KEYPAD_BOUNCE_EN
module keypad_emulator #(
  parameter int HOLD_CYCLES = 8,
  parameter int BOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  keypad_if.slave kp
);
  localparam logic [1:0] IDLE = 2'd0, BOUNCE_IN = 2'd1, HELD = 2'd2, BOUNCE_OUT = 2'd3;
  localparam logic [15:0] HOLD_LD = 16'(HOLD_CYCLES - 1);
`ifdef KEYPAD_BOUNCE_EN
  localparam logic [15:0] BOUNCE_LD = 16'(BOUNCE_CYCLES - 1);
`endif
  logic [1:0] state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] key_q, key_d;
  logic contact_q, contact_d, done_q, done_d, err_q, err_d;
  logic busy, accept, row_on;
  logic [1:0] row, col;
  logic [3:0] rows;
  assign busy = state_q != IDLE;
  assign accept = kp.press && !busy && kp.key_code <= 4'd11;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    key_d = key_q;
    contact_d = contact_q;
    done_d = 1'b0;
    err_d = kp.press && !accept;
    if (accept) begin
      key_d = kp.key_code;
      contact_d = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
      state_d = BOUNCE_IN;
      cnt_d = BOUNCE_LD;
`else
      state_d = HELD;
      cnt_d = HOLD_LD;
`endif
    end else if (state_q == HELD) begin
      if (cnt_q == 16'd0) begin
        contact_d = 1'b0;
`ifdef KEYPAD_BOUNCE_EN
        state_d = BOUNCE_OUT;
        cnt_d = BOUNCE_LD;
`else
        state_d = IDLE;
        done_d = 1'b1;
`endif
      end else cnt_d = cnt_q - 16'd1;
    end
`ifdef KEYPAD_BOUNCE_EN
    else if (state_q == BOUNCE_IN) begin
      if (cnt_q == 16'd0) begin
        state_d = HELD;
        cnt_d = HOLD_LD;
        contact_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 16'd1;
        contact_d = !contact_q;
      end
    end else if (state_q == BOUNCE_OUT) begin
      if (cnt_q == 16'd0) begin
        state_d = IDLE;
        contact_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 16'd1;
        contact_d = !contact_q;
      end
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      key_q <= '0;
      contact_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
      contact_q <= contact_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // row 0..3 = B,G,F,D; col 0..2 = C,A,E
  always_comb begin
    row = (key_q == 4'd0 || key_q >= 4'd10) ? 2'd3 : key_q <= 4'd3 ? 2'd0 : key_q <= 4'd6 ? 2'd1 : 2'd2;
    col = (key_q == 4'd1 || key_q == 4'd4 || key_q == 4'd7 || key_q == 4'd10) ? 2'd0 :
          (key_q == 4'd2 || key_q == 4'd5 || key_q == 4'd8 || key_q == 4'd0) ? 2'd1 : 2'd2;
  end
  assign rows = {kp.D, kp.F, kp.G, kp.B};
  assign row_on = contact_q && rows[row];
  assign kp.C = row_on && col == 2'd0;
  assign kp.A = row_on && col == 2'd1;
  assign kp.E = row_on && col == 2'd2;
  assign kp.busy = busy;
  assign kp.done = done_q;
  assign kp.err = err_q;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed checks of press timing, column decode, rejection and reset abort
module tb_keypad_emulator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  keypad_if kp();
  keypad_emulator #(.HOLD_CYCLES(8), .BOUNCE_CYCLES(4)) dut (.clk(clk), .reset(reset), .kp(kp));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic c, input logic a, input logic e, input logic b);
    chk({tag, ".C"}, kp.C, c);
    chk({tag, ".A"}, kp.A, a);
    chk({tag, ".E"}, kp.E, e);
    chk({tag, ".busy"}, kp.busy, b);
  endtask

  task automatic rows(input logic b, input logic g, input logic f, input logic d);
    kp.B = b; kp.G = g; kp.F = f; kp.D = d;
  endtask

  initial begin
    kp.key_code = 4'd0; kp.press = 1'b0;
    rows(0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.done", kp.done, 1'b0);
    chk("reset.err", kp.err, 1'b0);
`ifndef KEYPAD_BOUNCE_EN
    // key 4 held 8 cycles with row G
    rows(0, 1, 0, 0);
    kp.key_code = 4'd4; kp.press = 1'b1;
    tick();
    kp.press = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_out("k4.held", 1, 0, 0, 1);
      chk("k4.nodone", kp.done, 1'b0);
      tick();
    end
    chk_out("k4.end", 0, 0, 0, 0);
    chk("k4.done", kp.done, 1'b1);
    tick();
    chk("k4.done_1cyc", kp.done, 1'b0);
    // key 4 with scanned rows
    kp.key_code = 4'd4; kp.press = 1'b1;
    tick();
    kp.press = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rows(i % 4 == 0, i % 4 == 1, i % 4 == 2, i % 4 == 3);
      #1;
      chk_out("scan", i % 4 == 1, 0, 0, 1);
      tick();
    end
    chk("scan.done", kp.done, 1'b1);
    // invalid key
    rows(1, 1, 1, 1);
    kp.key_code = 4'd13; kp.press = 1'b1;
    tick();
    kp.press = 1'b0;
    chk("inv.err", kp.err, 1'b1);
    chk_out("inv", 0, 0, 0, 0);
    tick();
    chk("inv.err_1cyc", kp.err, 1'b0);
    chk_out("inv.after", 0, 0, 0, 0);
    // key 11 with all rows high, second press rejected while busy
    kp.key_code = 4'd11; kp.press = 1'b1;
    tick();
    kp.press = 1'b0;
    chk_out("k11.c1", 0, 0, 1, 1);
    tick();
    tick();
    kp.key_code = 4'd7; kp.press = 1'b1;
    tick();
    kp.press = 1'b0;
    chk("k11.err", kp.err, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk_out("k11.held", 0, 0, 1, 1);
      chk("k11.nodone", kp.done, 1'b0);
      tick();
    end
    chk("k11.done", kp.done, 1'b1);
    chk_out("k11.end", 0, 0, 0, 0);
    // key 0, reset mid-hold
    rows(0, 0, 0, 1);
    kp.key_code = 4'd0; kp.press = 1'b1;
    tick();
    kp.press = 1'b0;
    chk_out("k0.c1", 0, 1, 0, 1);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("k0.rst", 0, 0, 0, 0);
    chk("k0.rst_nodone", kp.done, 1'b0);
    tick();
    chk("k0.rst_nodone2", kp.done, 1'b0);
    // reset wins over simultaneous press
    reset = 1'b1; kp.press = 1'b1;
    tick();
    reset = 1'b0; kp.press = 1'b0;
    chk_out("rstpress", 0, 0, 0, 0);
    kp.press = 1'b1;
    tick();
    kp.press = 1'b0;
    chk_out("k0.again", 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) tick();
    chk("k0.again_done", kp.done, 1'b1);
    // back-to-back: press at done edge rejected, next cycle accepted
    rows(1, 0, 0, 0);
    kp.key_code = 4'd1; kp.press = 1'b1;
    tick();
    kp.press = 1'b0;
    chk_out("k1", 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) tick();
    kp.key_code = 4'd2; kp.press = 1'b1;
    tick();
    chk("b2b.done", kp.done, 1'b1);
    chk("b2b.err", kp.err, 1'b1);
    chk_out("b2b.idle", 0, 0, 0, 0);
    tick();
    kp.press = 1'b0;
    chk("b2b.err_clr", kp.err, 1'b0);
    chk_out("k2", 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) tick();
    chk("k2.done", kp.done, 1'b1);
`else
    // key 5 with bounce in and out
    rows(0, 1, 0, 0);
    kp.key_code = 4'd5; kp.press = 1'b1;
    tick();
    kp.press = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_out("bnc", 0, i < 4 ? i % 2 == 0 : i < 12 ? 1'b1 : i % 2 == 1, 0, 1);
      chk("bnc.nodone", kp.done, 1'b0);
      tick();
    end
    chk("bnc.done", kp.done, 1'b1);
    chk_out("bnc.end", 0, 0, 0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
